regfile_rd2w1: RTL and testbench

Parametrised register file: DEPTH registers of WIDTH bits with one synchronous write port and two independent read ports (A and B). It replaces the standalone 16:1 16-bit register-select multiplexer in the datapath. It adds:
- register storage;
- write-to-read bypass;
- optional hardwired zero register;
- optional registered read outputs with a valid flag.

It feeds the ALU operand buses and is written from the writeback stage.

---
 rtl/regfile_rd2w1.sv | 79 +++++++
 tb/tb_regfile_rd2w1.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/regfile_rd2w1.sv
// Register file: DEPTH x WIDTH, one synchronous write port, two read ports A/B,
// write-first bypass, optional hardwired zero register and optional registered reads.
module regfile_rd2w1 #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int ZERO_REG = 1,
  parameter int REG_OUT  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  output logic             rvalid
);

  // Storage covers the whole address space so any address indexes safely;
  // entries at or above DEPTH are never written and never read out.
  localparam int NREG = 1 << AW;
  localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [NREG];
  logic [WIDTH-1:0] rv_a, rv_b;
  logic [WIDTH-1:0] q_a, q_b;
  logic             q_valid;
  logic             wr_ok;

  function automatic logic in_range(input logic [AW-1:0] addr);
    return {1'b0, addr} < DEPTH_W;
  endfunction

  function automatic logic is_zero_reg(input logic [AW-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  assign wr_ok = we && in_range(waddr) && !is_zero_reg(waddr);

  // Read priority: out of range, zero register, same-cycle write, storage.
  always_comb begin
    rv_a = '0;
    rv_b = '0;
    if (in_range(raddr_a) && !is_zero_reg(raddr_a))
      rv_a = (we && waddr == raddr_a) ? wdata : mem[raddr_a];
    if (in_range(raddr_b) && !is_zero_reg(raddr_b))
      rv_b = (we && waddr == raddr_b) ? wdata : mem[raddr_b];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem     <= '{default: '0};
      q_a     <= '0;
      q_b     <= '0;
      q_valid <= 1'b0;
    end else begin
      if (wr_ok)
        mem[waddr] <= wdata;
      if (re) begin
        q_a     <= rv_a;
        q_b     <= rv_b;
        q_valid <= 1'b1;
      end else begin
        q_valid <= 1'b0;
      end
    end
  end

  // rvalid qualifies rdata_a/rdata_b in the same cycle; there is no ready,
  // so each valid result is presented for exactly one cycle and never stalls.
  assign rdata_a = (REG_OUT != 0) ? q_a : rv_a;
  assign rdata_b = (REG_OUT != 0) ? q_b : rv_b;
  assign rvalid  = (REG_OUT != 0) ? q_valid : 1'b1;

endmodule

// File: tb/tb_regfile_rd2w1.sv
// Bench for regfile_rd2w1: two configurations driven by shared inputs,
// each checked against a behavioural register-file model via expected queues.
module tb_regfile_rd2w1;

  logic        clk = 1'b0;
  logic        rst, we, re;
  logic [3:0]  waddr, raddr_a, raddr_b;
  logic [15:0] wdata;
  logic [15:0] rdata_a0, rdata_b0, rdata_a1, rdata_b1;
  logic        rvalid0, rvalid1;

  int vectors = 0;
  int miscompares = 0;

  // Config 0: 16 regs, zero register, combinational read.
  // Config 1: 12 regs, ordinary register 0, registered read.
  logic [31:0] exp_q0[$];
  logic [32:0] exp_q1[$];
  logic [15:0] model0 [16];
  logic [15:0] model1 [16];
  logic [15:0] hold_a1 = '0, hold_b1 = '0;
  event        drv_ev;

  always #5 clk = ~clk;

  regfile_rd2w1 #(.WIDTH(16), .DEPTH(16), .AW(4), .ZERO_REG(1), .REG_OUT(0)) dut0 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .re(re),
    .raddr_a(raddr_a), .raddr_b(raddr_b),
    .rdata_a(rdata_a0), .rdata_b(rdata_b0), .rvalid(rvalid0)
  );

  regfile_rd2w1 #(.WIDTH(16), .DEPTH(12), .AW(4), .ZERO_REG(0), .REG_OUT(1)) dut1 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .re(re),
    .raddr_a(raddr_a), .raddr_b(raddr_b),
    .rdata_a(rdata_a1), .rdata_b(rdata_b1), .rvalid(rvalid1)
  );

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // Reference read value straight from the register-file rules.
  function automatic logic [15:0] model_read(input int cfg, input int addr);
    int depth = (cfg == 0) ? 16 : 12;
    bit zr    = (cfg == 0);
    if (addr >= depth) return 16'h0;
    if (zr && addr == 0) return 16'h0;
    if (we && int'(waddr) == addr) return wdata;
    return (cfg == 0) ? model0[addr] : model1[addr];
  endfunction

  task automatic drive_cycle(input bit r, input bit w, input int wa, input logic [15:0] wd,
                             input bit e, input int ra, input int rb);
    rst = r; we = w; waddr = 4'(wa); wdata = wd; re = e;
    raddr_a = 4'(ra); raddr_b = 4'(rb);
    exp_q0.push_back({model_read(0, ra), model_read(0, rb)});
    if (r) begin
      hold_a1 = '0; hold_b1 = '0;
      exp_q1.push_back({1'b0, 32'h0});
    end else if (e) begin
      hold_a1 = model_read(1, ra); hold_b1 = model_read(1, rb);
      exp_q1.push_back({1'b1, hold_a1, hold_b1});
    end else begin
      exp_q1.push_back({1'b0, hold_a1, hold_b1});
    end
    ->drv_ev;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 16; i++) begin model0[i] = '0; model1[i] = '0; end
    end else if (w) begin
      if (wa != 0) model0[wa] = wd;
      if (wa < 12) model1[wa] = wd;
    end
    @(negedge clk);
  endtask

  // Combinational port: output is presented (rvalid=1) every cycle.
  initial begin
    logic [31:0] e0;
    forever begin
      @(drv_ev);
      #2;
      if (exp_q0.size() > 0) begin
        e0 = exp_q0.pop_front();
        check("comb_rvalid", 16'(rvalid0), 16'h1);
        check("comb_a", rdata_a0, e0[31:16]);
        check("comb_b", rdata_b0, e0[15:0]);
      end
    end
  end

  // Registered port: result of each edge is checked just after that edge.
  initial begin
    logic [32:0] e1;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q1.size() > 0) begin
        e1 = exp_q1.pop_front();
        check("reg_rvalid", 16'(rvalid1), 16'(e1[32]));
        check("reg_a", rdata_a1, e1[31:16]);
        check("reg_b", rdata_b1, e1[15:0]);
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) begin model0[i] = '0; model1[i] = '0; end
    rst = 1'b1; we = 1'b0; re = 1'b0; waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
    #1;
    drive_cycle(1, 0, 0, 16'h0, 0, 0, 0);
    drive_cycle(1, 0, 0, 16'h0, 0, 0, 0);
    // Post-reset reads of every address: without re, then with re.
    for (int i = 0; i < 16; i++) drive_cycle(0, 0, 0, 16'h0, 0, i, 15 - i);
    for (int i = 0; i < 16; i++) drive_cycle(0, 0, 0, 16'h0, 1, i, 15 - i);
    // Write then read back, two registers.
    drive_cycle(0, 1, 5, 16'hBEEF, 0, 0, 0);
    drive_cycle(0, 0, 0, 16'h0, 1, 5, 5);
    drive_cycle(0, 1, 15, 16'h1234, 0, 0, 0);
    drive_cycle(0, 0, 0, 16'h0, 1, 15, 5);
    // Same-cycle write/read hazard on r7.
    drive_cycle(0, 1, 7, 16'h0001, 0, 0, 0);
    drive_cycle(0, 1, 7, 16'hA5A5, 1, 7, 7);
    drive_cycle(0, 0, 0, 16'h0, 1, 7, 0);
    // Register 0: hardwired in config 0, ordinary in config 1.
    drive_cycle(0, 1, 0, 16'hFFFF, 1, 0, 1);
    drive_cycle(0, 0, 0, 16'h0, 1, 0, 0);
    // Out-of-range write for the 12-entry file.
    drive_cycle(0, 1, 11, 16'h0B0B, 0, 0, 0);
    drive_cycle(0, 1, 13, 16'h7777, 0, 0, 0);
    drive_cycle(0, 0, 0, 16'h0, 1, 13, 11);
    // re pulses with holds in between.
    drive_cycle(0, 0, 0, 16'h0, 1, 5, 15);
    drive_cycle(0, 0, 0, 16'h0, 0, 1, 2);
    drive_cycle(0, 0, 0, 16'h0, 1, 7, 11);
    drive_cycle(0, 0, 0, 16'h0, 0, 3, 4);
    // Reset mid-stream with re=1, then read everything back.
    drive_cycle(0, 0, 0, 16'h0, 1, 5, 7);
    drive_cycle(1, 1, 3, 16'h3333, 1, 5, 7);
    drive_cycle(0, 1, 9, 16'h9999, 1, 9, 5);
    for (int i = 0; i < 16; i++) drive_cycle(0, 0, 0, 16'h0, 1, i, i);
    // Random traffic with occasional reset.
    for (int n = 0; n < 400; n++)
      drive_cycle($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 15), 16'($urandom), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 15), $urandom_range(0, 15));
    drive_cycle(0, 0, 0, 16'h0, 0, 0, 0);
    @(posedge clk);
    #3;
    check("q0_drained", 16'(exp_q0.size()), 16'h0);
    check("q1_drained", 16'(exp_q1.size()), 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
